// File: rtl/exc_commit_pkg.sv
// Shared encodings for the MEM->WB exception/commit arbiter:
// CP0 exc_type bit order, raw MEM flag order and FSM states.
package exc_commit_pkg;

   localparam int EXC_INT  = 6;
   localparam int EXC_ADEL = 5;
   localparam int EXC_ADES = 4;
   localparam int EXC_SYS  = 3;
   localparam int EXC_BP   = 2;
   localparam int EXC_RI   = 1;
   localparam int EXC_OV   = 0;

   localparam int RAW_ADEL_IF = 6;
   localparam int RAW_RI      = 5;
   localparam int RAW_OV      = 4;
   localparam int RAW_SYS     = 3;
   localparam int RAW_BP      = 2;
   localparam int RAW_ADEL_LD = 1;
   localparam int RAW_ADES    = 0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational MIPS exception priority pick: one-hot exc_type,
// eret qualification and bad_vaddr source select.
module exc_prio_enc
   import exc_commit_pkg::*;
(
   input  logic        i_int,
   input  logic [6:0]  i_exc,
   input  logic        i_eret,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_daddr,
   output logic [6:0]  o_exc_type,
   output logic        o_is_eret,
   output logic        o_trap,
   output logic [31:0] o_bad_vaddr
);

   always_comb begin
      o_exc_type  = '0;
      o_is_eret   = 1'b0;
      o_bad_vaddr = '0;
      if (i_int) begin
         o_exc_type[EXC_INT] = 1'b1;
      end else if (i_exc[RAW_ADEL_IF]) begin
         o_exc_type[EXC_ADEL] = 1'b1;
         o_bad_vaddr          = i_pc;
      end else if (i_exc[RAW_RI]) begin
         o_exc_type[EXC_RI] = 1'b1;
      end else if (i_exc[RAW_OV]) begin
         o_exc_type[EXC_OV] = 1'b1;
      end else if (i_exc[RAW_SYS]) begin
         o_exc_type[EXC_SYS] = 1'b1;
      end else if (i_exc[RAW_BP]) begin
         o_exc_type[EXC_BP] = 1'b1;
      end else if (i_exc[RAW_ADEL_LD]) begin
         o_exc_type[EXC_ADEL] = 1'b1;
         o_bad_vaddr          = i_daddr;
      end else if (i_exc[RAW_ADES]) begin
         o_exc_type[EXC_ADES] = 1'b1;
         o_bad_vaddr          = i_daddr;
      end else if (i_eret) begin
         o_is_eret = 1'b1;
      end
   end

   assign o_trap = i_int | (|i_exc) | i_eret;

endmodule

// File: rtl/exc_commit.sv
// MEM->WB exception/commit arbiter: drives CP0 strobes, a one-cycle
// pipeline flush, and holds the fetch redirect until accepted.
module exc_commit
   import exc_commit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_pc,
   input  logic        mem_is_slot,
   input  logic [6:0]  mem_exc,
   input  logic        mem_eret,
   input  logic [31:0] mem_daddr,
   input  logic        int_happen,
   input  logic [31:0] EPC,
   output logic        commit_ok,
   output logic [6:0]  exc_type,
   output logic [31:0] exc_pc,
   output logic        is_slot,
   output logic [31:0] bad_vaddr,
   output logic        eret,
   output logic        flush,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc
);

   state_t      r_state;
   state_t      w_next;
   logic        r_commit_ok;
   logic [6:0]  r_exc_type;
   logic        r_eret;
   logic [31:0] r_exc_pc;
   logic        r_is_slot;
   logic [31:0] r_bad_vaddr;
   logic [31:0] r_redirect_pc;

   logic        w_accept;
   logic        w_take;
   logic [6:0]  w_exc_type;
   logic        w_is_eret;
   logic        w_trap;
   logic [31:0] w_bad_vaddr;

   // Interrupts only attach to an instruction actually being committed.
   assign w_accept = mem_valid & (r_state == ST_IDLE);
   assign w_take   = w_accept & w_trap;

   exc_prio_enc u_prio (
      .i_int       (int_happen & w_accept),
      .i_exc       (mem_exc),
      .i_eret      (mem_eret),
      .i_pc        (mem_pc),
      .i_daddr     (mem_daddr),
      .o_exc_type  (w_exc_type),
      .o_is_eret   (w_is_eret),
      .o_trap      (w_trap),
      .o_bad_vaddr (w_bad_vaddr)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:     if (w_take) w_next = ST_FLUSH;
         ST_FLUSH:    w_next = redirect_ready ? ST_IDLE : ST_REDIRECT;
         ST_REDIRECT: if (redirect_ready) w_next = ST_IDLE;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_commit_ok   <= 1'b0;
         r_exc_type    <= '0;
         r_eret        <= 1'b0;
         r_exc_pc      <= '0;
         r_is_slot     <= 1'b0;
         r_bad_vaddr   <= '0;
         r_redirect_pc <= '0;
      end else begin
         r_state     <= w_next;
         r_commit_ok <= w_accept & ~w_trap;
         r_exc_type  <= w_take ? w_exc_type : '0;
         r_eret      <= w_take & w_is_eret;
         if (w_take) begin
            r_exc_pc      <= mem_pc;
            r_is_slot     <= mem_is_slot;
            r_bad_vaddr   <= w_bad_vaddr;
            r_redirect_pc <= w_is_eret ? EPC : EXC_VECTOR;
         end
      end
   end

   assign mem_ready      = (r_state == ST_IDLE);
   assign flush          = (r_state == ST_FLUSH);
   assign redirect_valid = (r_state != ST_IDLE);
   assign commit_ok      = r_commit_ok;
   assign exc_type       = r_exc_type;
   assign eret           = r_eret;
   assign exc_pc         = r_exc_pc;
   assign is_slot        = r_is_slot;
   assign bad_vaddr      = r_bad_vaddr;
   assign redirect_pc    = r_redirect_pc;

endmodule
